// File: rtl/block_slice_stats.sv
// Per-slice statistics: accumulates sum/min/max/count over one block slice and
// emits one beat per slice, with band/image flags and a protocol-error bit.
module block_slice_stats #(
  parameter int DATA_WIDTH           = 16,
  parameter int MAX_BLOCK_SAMPLE_LOG = 4,
  parameter int MAX_BLOCK_LINE_LOG   = 4,
  localparam int CNT_WIDTH = MAX_BLOCK_SAMPLE_LOG + MAX_BLOCK_LINE_LOG + 1,
  localparam int SUM_WIDTH = DATA_WIDTH + MAX_BLOCK_SAMPLE_LOG + MAX_BLOCK_LINE_LOG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic                  input_last_s,
  input  logic                  input_last_r,
  input  logic                  input_last_b,
  input  logic                  input_last_i,
  input  logic                  input_valid,
  output logic                  input_ready,
  output logic [SUM_WIDTH-1:0]  output_sum,
  output logic [DATA_WIDTH-1:0] output_min,
  output logic [DATA_WIDTH-1:0] output_max,
  output logic [CNT_WIDTH-1:0]  output_count,
  output logic                  output_last_b,
  output logic                  output_last_i,
  output logic                  output_error,
  output logic                  output_valid,
  input  logic                  output_ready
);

  // Handshake: a beat moves on a rising edge when valid and ready are both high.
  // Once output_valid rises, the output beat is held stable until output_ready.
  typedef enum logic [1:0] {
    S_IDLE       = 2'b00,
    S_ACCUM      = 2'b01,
    S_HOLD       = 2'b10,
    S_ACCUM_HOLD = 2'b11
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {1'b1, {(CNT_WIDTH-1){1'b0}}};

  state_e state_q, state_d;

  logic [SUM_WIDTH-1:0]  acc_sum_q;
  logic [DATA_WIDTH-1:0] acc_min_q, acc_max_q;
  logic [CNT_WIDTH-1:0]  acc_cnt_q;
  logic                  acc_err_q;

  logic [SUM_WIDTH-1:0]  out_sum_q;
  logic [DATA_WIDTH-1:0] out_min_q, out_max_q;
  logic [CNT_WIDTH-1:0]  out_cnt_q;
  logic                  out_last_b_q, out_last_i_q, out_err_q;

  logic [SUM_WIDTH-1:0]  nxt_sum;
  logic [DATA_WIDTH-1:0] nxt_min, nxt_max;
  logic [CNT_WIDTH-1:0]  nxt_cnt;
  logic                  nxt_err;
  logic [SUM_WIDTH:0]    sum_ext;
  logic [SUM_WIDTH-1:0]  data_ext;

  logic first, out_valid, in_fire, out_fire, slice_end;
  logic acc_busy, out_full;

  assign out_valid   = (state_q == S_HOLD) || (state_q == S_ACCUM_HOLD);
  assign first       = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign input_ready = !(out_valid && !output_ready);
  assign in_fire     = input_valid && input_ready;
  assign out_fire    = out_valid && output_ready;
  assign slice_end   = input_last_s && input_last_r;

  // Accumulator occupancy and output occupancy are tracked independently.
  always_comb begin
    acc_busy = !first;
    out_full = out_valid;
    if (in_fire) acc_busy = !slice_end;
    if (in_fire && slice_end) out_full = 1'b1;
    else if (out_fire)        out_full = 1'b0;
    case ({out_full, acc_busy})
      2'b00:   state_d = S_IDLE;
      2'b01:   state_d = S_ACCUM;
      2'b10:   state_d = S_HOLD;
      default: state_d = S_ACCUM_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Contribution of the current sample; count and sum saturate instead of wrapping.
  always_comb begin
    data_ext = SUM_WIDTH'(input_data);
    sum_ext  = '0;
    nxt_sum  = data_ext;
    nxt_min  = input_data;
    nxt_max  = input_data;
    nxt_cnt  = CNT_WIDTH'(1);
    nxt_err  = 1'b0;
    if (!first) begin
      sum_ext = {1'b0, acc_sum_q} + {1'b0, data_ext};
      nxt_sum = sum_ext[SUM_WIDTH] ? '1 : sum_ext[SUM_WIDTH-1:0];
      nxt_min = (input_data < acc_min_q) ? input_data : acc_min_q;
      nxt_max = (input_data > acc_max_q) ? input_data : acc_max_q;
      nxt_err = acc_err_q;
      if (acc_cnt_q == CNT_MAX) begin
        nxt_cnt = acc_cnt_q;
        nxt_err = 1'b1;
      end else begin
        nxt_cnt = acc_cnt_q + CNT_WIDTH'(1);
      end
    end
    if (input_last_r && !input_last_s)                 nxt_err = 1'b1;
    if ((input_last_b || input_last_i) && !slice_end)  nxt_err = 1'b1;
    if ((nxt_cnt == CNT_MAX) && !slice_end)            nxt_err = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sum_q    <= '0;
      acc_min_q    <= '0;
      acc_max_q    <= '0;
      acc_cnt_q    <= '0;
      acc_err_q    <= 1'b0;
      out_sum_q    <= '0;
      out_min_q    <= '0;
      out_max_q    <= '0;
      out_cnt_q    <= '0;
      out_last_b_q <= 1'b0;
      out_last_i_q <= 1'b0;
      out_err_q    <= 1'b0;
    end else if (in_fire) begin
      if (slice_end) begin
        out_sum_q    <= nxt_sum;
        out_min_q    <= nxt_min;
        out_max_q    <= nxt_max;
        out_cnt_q    <= nxt_cnt;
        out_err_q    <= nxt_err;
        out_last_b_q <= input_last_b;
        out_last_i_q <= input_last_i;
      end else begin
        acc_sum_q <= nxt_sum;
        acc_min_q <= nxt_min;
        acc_max_q <= nxt_max;
        acc_cnt_q <= nxt_cnt;
        acc_err_q <= nxt_err;
      end
    end
  end

  assign output_sum    = out_sum_q;
  assign output_min    = out_min_q;
  assign output_max    = out_max_q;
  assign output_count  = out_cnt_q;
  assign output_last_b = out_last_b_q;
  assign output_last_i = out_last_i_q;
  assign output_error  = out_err_q;
  assign output_valid  = out_valid;

endmodule

// File: tb/tb_block_slice_stats.sv
// Bench for block_slice_stats: vector table, directed corner sequences and
// random slices checked against a queue-based slice model.
module tb_block_slice_stats;
  localparam int DW = 16;
  localparam int SW = 24;
  localparam int CW = 9;
  localparam int BW = SW + 2*DW + CW + 3;
  localparam int MAXCNT = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] input_data;
  logic          input_last_s, input_last_r, input_last_b, input_last_i;
  logic          input_valid, input_ready;
  logic [SW-1:0] output_sum;
  logic [DW-1:0] output_min, output_max;
  logic [CW-1:0] output_count;
  logic          output_last_b, output_last_i, output_error;
  logic          output_valid, output_ready;

  int checks = 0;
  int failures = 0;
  bit rand_rdy = 1'b0;

  logic [DW-1:0] cur_q[$];
  bit            cur_err = 1'b0;
  logic [BW-1:0] exp_q[$];

  always #5 clk = ~clk;

  block_slice_stats #(
    .DATA_WIDTH(16), .MAX_BLOCK_SAMPLE_LOG(4), .MAX_BLOCK_LINE_LOG(4)
  ) dut (
    .clk(clk), .rst(rst),
    .input_data(input_data), .input_last_s(input_last_s), .input_last_r(input_last_r),
    .input_last_b(input_last_b), .input_last_i(input_last_i),
    .input_valid(input_valid), .input_ready(input_ready),
    .output_sum(output_sum), .output_min(output_min), .output_max(output_max),
    .output_count(output_count), .output_last_b(output_last_b), .output_last_i(output_last_i),
    .output_error(output_error), .output_valid(output_valid), .output_ready(output_ready)
  );

  typedef struct {
    int                 n;
    logic [3:0][DW-1:0] d;
    logic [3:0][3:0]    f;   // per sample {last_s, last_r, last_b, last_i}
    logic [SW-1:0]      sum;
    logic [DW-1:0]      mn;
    logic [DW-1:0]      mx;
    logic [CW-1:0]      cnt;
    logic               lb;
    logic               li;
    logic               err;
  } vec_t;

  vec_t tbl[7];

  // Slice model: collect the samples, then derive the statistics from the list.
  task automatic model_accept(input logic [DW-1:0] d, input logic s, input logic r,
                              input logic b, input logic i);
    longint unsigned total;
    logic [DW-1:0]   mn, mx;
    logic [SW-1:0]   sm;
    logic [CW-1:0]   c;
    bit              e;
    cur_q.push_back(d);
    if (r && !s) cur_err = 1'b1;
    if ((b || i) && !(s && r)) cur_err = 1'b1;
    if (s && r) begin
      total = 0;
      mn = '1;
      mx = '0;
      foreach (cur_q[k]) begin
        total += longint'(cur_q[k]);
        if (cur_q[k] < mn) mn = cur_q[k];
        if (cur_q[k] > mx) mx = cur_q[k];
      end
      sm = (total > 64'hFF_FFFF) ? '1 : total[SW-1:0];
      c  = (cur_q.size() > MAXCNT) ? CW'(MAXCNT) : CW'(cur_q.size());
      e  = cur_err || (cur_q.size() > MAXCNT);
      exp_q.push_back({sm, mn, mx, c, b, i, e});
      cur_q.delete();
      cur_err = 1'b0;
    end
  endtask

  task automatic observe();
    logic [BW-1:0] act, ex;
    if (rst) begin
      cur_q.delete();
      cur_err = 1'b0;
      exp_q.delete();
    end else begin
      if (input_valid && input_ready)
        model_accept(input_data, input_last_s, input_last_r, input_last_b, input_last_i);
      if (output_valid && output_ready) begin
        act = {output_sum, output_min, output_max, output_count,
               output_last_b, output_last_i, output_error};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected got=%h", act);
        end else begin
          ex = exp_q.pop_front();
          if (act !== ex) begin
            failures++;
            $display("FAIL beat_model got=%h exp=%h", act, ex);
          end
        end
      end
    end
  endtask

  task automatic step(output bit acc);
    @(negedge clk);
    acc = input_valid && input_ready;
    observe();
    @(posedge clk);
    #1;
    if (rand_rdy) output_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) step(a);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [3:0] f);
    bit acc;
    int guard;
    input_data = d;
    {input_last_s, input_last_r, input_last_b, input_last_i} = f;
    input_valid = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 300) begin
      step(acc);
      guard++;
    end
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_timeout got=not_accepted exp=accepted data=%h", d);
    end
    input_valid = 1'b0;
    {input_last_s, input_last_r, input_last_b, input_last_i} = 4'b0000;
  endtask

  task automatic check_beat(input string nm, input logic [SW-1:0] s, input logic [DW-1:0] mn,
                            input logic [DW-1:0] mx, input logic [CW-1:0] c,
                            input logic lb, input logic li, input logic er);
    logic [BW:0] act, ex;
    act = {output_valid, output_sum, output_min, output_max, output_count,
           output_last_b, output_last_i, output_error};
    ex  = {1'b1, s, mn, mx, c, lb, li, er};
    checks++;
    if (act !== ex) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, ex);
    end
  endtask

  task automatic check_bit(input string nm, input logic act, input logic ex);
    checks++;
    if (act !== ex) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", nm, act, ex);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    logic [BW:0] act;
    act = {output_valid, output_sum, output_min, output_max, output_count,
           output_last_b, output_last_i, output_error};
    checks++;
    if (act !== '0) begin
      failures++;
      $display("FAIL %s got=%h exp=0", nm, act);
    end
  endtask

  initial begin
    bit            acc;
    int            len, guard;
    logic [DW-1:0] d;
    logic [3:0]    f;

    tbl[0] = '{4, {16'd4, 16'd3, 16'd2, 16'd1}, {4'b1111, 4'b0000, 4'b1000, 4'b0000},
               24'd10, 16'd1, 16'd4, 9'd4, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{3, {16'd0, 16'd3, 16'd9, 16'd5}, {4'b0000, 4'b1100, 4'b0100, 4'b0000},
               24'd17, 16'd3, 16'd9, 9'd3, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1, {16'd0, 16'd0, 16'd0, 16'd7}, {4'b0000, 4'b0000, 4'b0000, 4'b1100},
               24'd7, 16'd7, 16'd7, 9'd1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1, {16'd0, 16'd0, 16'd0, 16'd0}, {4'b0000, 4'b0000, 4'b0000, 4'b1110},
               24'd0, 16'd0, 16'd0, 9'd1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{2, {16'd0, 16'd0, 16'd20, 16'd10}, {4'b0000, 4'b0000, 4'b1100, 4'b0010},
               24'd30, 16'd10, 16'd20, 9'd2, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{3, {16'd0, 16'hFFFF, 16'd0, 16'hFFFF}, {4'b0000, 4'b1111, 4'b1000, 4'b1000},
               24'd131070, 16'd0, 16'hFFFF, 9'd3, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{3, {16'd0, 16'd1, 16'd2, 16'd3}, {4'b0000, 4'b1100, 4'b0000, 4'b0001},
               24'd6, 16'd1, 16'd3, 9'd3, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    input_data = '0;
    {input_last_s, input_last_r, input_last_b, input_last_i} = 4'b0000;
    input_valid = 1'b0;
    output_ready = 1'b0;
    idle(3);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    check_bit("ready_after_reset", input_ready, 1'b1);

    // Table of slices with the sink always ready; each beat must be up the cycle after.
    output_ready = 1'b1;
    for (int t = 0; t < 7; t++) begin
      for (int k = 0; k < tbl[t].n; k++) begin
        if (k == tbl[t].n - 1 && k > 0) check_bit("no_early_valid", output_valid, 1'b0);
        send(tbl[t].d[k], tbl[t].f[k]);
      end
      check_beat($sformatf("tbl%0d", t), tbl[t].sum, tbl[t].mn, tbl[t].mx, tbl[t].cnt,
                 tbl[t].lb, tbl[t].li, tbl[t].err);
    end
    idle(2);

    // Back-to-back single-sample slices at full rate.
    send(16'd7, 4'b1100);
    check_beat("b2b_first", 24'd7, 16'd7, 16'd7, 9'd1, 1'b0, 1'b0, 1'b0);
    check_bit("b2b_ready", input_ready, 1'b1);
    send(16'd0, 4'b1100);
    check_beat("b2b_second", 24'd0, 16'd0, 16'd0, 9'd1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Backpressure: slice A waits, slice B is refused until A drains.
    output_ready = 1'b0;
    send(16'd5, 4'b1100);
    input_data = 16'd6;
    input_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(acc);
      check_bit("bp_refused", acc, 1'b0);
      check_beat("bp_hold_stable", 24'd5, 16'd5, 16'd5, 9'd1, 1'b0, 1'b0, 1'b0);
    end
    output_ready = 1'b1;
    send(16'd6, 4'b0000);
    send(16'd9, 4'b1100);
    check_beat("bp_slice_b", 24'd15, 16'd6, 16'd9, 9'd2, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Full-size slice, then one sample beyond the maximum count.
    for (int k = 0; k < 256; k++) send(16'hFFFF, (k == 255) ? 4'b1100 : 4'b0000);
    check_beat("max_full", 24'hFF_FF00, 16'hFFFF, 16'hFFFF, 9'd256, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 257; k++) send(16'hFFFF, (k == 256) ? 4'b1100 : 4'b0000);
    check_beat("max_saturate", 24'hFF_FFFF, 16'hFFFF, 16'hFFFF, 9'd256, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Reset in the middle of a slice discards the partial accumulation.
    send(16'd8, 4'b0000);
    send(16'd8, 4'b0000);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset_state");
    idle(2);
    rst = 1'b0;
    check_bit("midreset_ready", input_ready, 1'b1);
    send(16'd1, 4'b0000);
    send(16'd1, 4'b1100);
    check_beat("after_reset", 24'd2, 16'd1, 16'd1, 9'd2, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Random slices with random sink stalls, checked against the model.
    rand_rdy = 1'b1;
    for (int s = 0; s < 40; s++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
        if (k == len - 1) begin
          f = {2'b11, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
        end else begin
          f[2] = ($urandom_range(0, 9) == 0);
          f[3] = f[2] ? 1'b0 : 1'($urandom_range(0, 1));
          f[1] = ($urandom_range(0, 19) == 0);
          f[0] = ($urandom_range(0, 19) == 0);
        end
        send(d, f);
      end
    end
    rand_rdy = 1'b0;
    output_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || output_valid) && guard < 50) begin
      step(acc);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0 || output_valid) begin
      failures++;
      $display("FAIL drain got=%0d_pending exp=0_pending", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
